instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 188 ++++++++++++++++++
 tb/tb_instr_encoder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Accepts decoded MIPS-style instruction fields over a
//               valid/ready handshake, encodes them into 32-bit instruction
//               words and writes them sequentially into an instruction
//               memory of 2**ADDR_W words (one word per two cycles at most).
//
// Ports       : clk, reset            - clock, synchronous active-high reset
//               clear                 - synchronous restart of load session
//               in_valid / in_ready   - field handshake
//               in_class              - 0=R,1=lw,2=sw,3=beq,4=addi,5=j
//               rs, rt, rd, shamt,
//               funct, imm, target    - instruction fields
//               imem_we/addr/wdata    - instruction-memory write port
//               count                 - words written since reset/clear
//               full                  - memory completely written
//               error                 - sticky illegal-class flag
//
// Config      : `define ENC_ILLEGAL_TRAP_EN to trap illegal classes (6..7)
//               instead of writing them as NOP words.
//
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              error
);

    localparam logic [5:0]        c_OP_RTYPE = 6'b000000;
    localparam logic [5:0]        c_OP_LW    = 6'b100011;
    localparam logic [5:0]        c_OP_SW    = 6'b101011;
    localparam logic [5:0]        c_OP_BEQ   = 6'b000100;
    localparam logic [5:0]        c_OP_ADDI  = 6'b001000;
    localparam logic [5:0]        c_OP_J     = 6'b000010;
    localparam logic [ADDR_W-1:0] c_PTR_MAX  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] c_PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   c_CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       wdata_q, wdata_d;
`ifdef ENC_ILLEGAL_TRAP_EN
    logic              error_q, error_d;
`endif

    logic [31:0]       w_enc_word;
    logic              w_illegal;
    logic              w_accept;

    // Ready is gated directly by reset/clear so a same-cycle clear or reset
    // can never complete a handshake.
    assign in_ready = (state_q == S_IDLE) & ~clear & ~reset;
    assign w_accept = in_valid & in_ready;

    // Field packing per instruction class; fields a class does not use are
    // simply not referenced for that class.
    always_comb begin
        w_enc_word = 32'h0000_0000;
        w_illegal  = 1'b0;
        case (in_class)
            3'd0:    w_enc_word = {c_OP_RTYPE, rs, rt, rd, shamt, funct};
            3'd1:    w_enc_word = {c_OP_LW,    rs, rt, imm};
            3'd2:    w_enc_word = {c_OP_SW,    rs, rt, imm};
            3'd3:    w_enc_word = {c_OP_BEQ,   rs, rt, imm};
            3'd4:    w_enc_word = {c_OP_ADDI,  rs, rt, imm};
            3'd5:    w_enc_word = {c_OP_J,     target};
            default: w_illegal  = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        wdata_d = wdata_q;
`ifdef ENC_ILLEGAL_TRAP_EN
        error_d = error_q;
`endif
        if (clear) begin
            // Aborts a pending write: the strobe already visible this cycle
            // completes, but no pointer/count advance follows it.
            state_d = S_IDLE;
            ptr_d   = '0;
            count_d = '0;
`ifdef ENC_ILLEGAL_TRAP_EN
            error_d = 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
`ifdef ENC_ILLEGAL_TRAP_EN
                        if (w_illegal) begin
                            error_d = 1'b1;
                        end else begin
                            wdata_d = w_enc_word;
                            state_d = S_WRITE;
                        end
`else
                        // Illegal classes encode as an all-zero NOP word.
                        wdata_d = w_enc_word;
                        state_d = S_WRITE;
`endif
                    end
                end
                S_WRITE: begin
                    count_d = count_q + c_CNT_ONE;
                    if (ptr_q == c_PTR_MAX) begin
                        // Pointer parks on the last address; no wrap.
                        state_d = S_FULL;
                    end else begin
                        ptr_d   = ptr_q + c_PTR_ONE;
                        state_d = S_IDLE;
                    end
                end
                S_FULL: begin
                    state_d = S_FULL;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            wdata_q <= 32'h0000_0000;
`ifdef ENC_ILLEGAL_TRAP_EN
            error_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            wdata_q <= wdata_d;
`ifdef ENC_ILLEGAL_TRAP_EN
            error_q <= error_d;
`endif
        end
    end

    assign imem_we    = (state_q == S_WRITE);
    assign imem_addr  = ptr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign full       = (state_q == S_FULL);
`ifdef ENC_ILLEGAL_TRAP_EN
    assign error      = error_q;
`else
    // The illegal class is only ever evaluated when trapping is enabled.
    logic w_unused_illegal;
    assign w_unused_illegal = w_illegal;
    assign error      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder
// Description : Self-checking bench for instr_encoder (ADDR_W = 2). A
//               transaction-level model (pending write, word count, full and
//               error flags) predicts every output each cycle; directed
//               sequences pin literal encodings and boundary behaviour, then
//               randomized traffic with clears and resets runs against the
//               model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

    localparam int ADDR_W = 2;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef ENC_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              clear = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2:0]        in_class = '0;
    logic [4:0]        rs = '0, rt = '0, rd = '0, shamt = '0;
    logic [5:0]        funct = '0;
    logic [15:0]       imm = '0;
    logic [25:0]       target = '0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              error;

    instr_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
        .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm(imm), .target(target),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .count(count), .full(full), .error(error)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Encoding straight from the instruction-format table.
    function automatic logic [31:0] enc(input logic [2:0] c, input logic [4:0] a, b, d, s,
                                        input logic [5:0] f, input logic [15:0] im,
                                        input logic [25:0] t);
        case (c)
            3'd0: return {6'b000000, a, b, d, s, f};
            3'd1: return {6'b100011, a, b, im};
            3'd2: return {6'b101011, a, b, im};
            3'd3: return {6'b000100, a, b, im};
            3'd4: return {6'b001000, a, b, im};
            3'd5: return {6'b000010, t};
            default: return 32'h0;
        endcase
    endfunction

    // ---------------- transaction-level model ----------------
    bit          m_pend  = 0;   // a word is being strobed this cycle
    int          m_count = 0;
    bit          m_full  = 0;
    bit          m_err   = 0;
    logic [31:0] m_wdata = 32'h0;
    bit          chk_en  = 0;

    function automatic bit m_ready();
        return !reset && !clear && !m_pend && !m_full;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_pend = 0; m_count = 0; m_full = 0; m_err = 0; m_wdata = 32'h0;
        end else if (clear) begin
            m_pend = 0; m_count = 0; m_full = 0; m_err = 0;
        end else if (m_pend) begin
            m_pend = 0;
            m_count++;
            if (m_count == DEPTH) m_full = 1;
        end else if (in_valid && m_ready()) begin
            if (TRAP && in_class > 3'd5) begin
                m_err = 1;
            end else begin
                m_pend  = 1;
                m_wdata = enc(in_class, rs, rt, rd, shamt, funct, imm, target);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready",   {63'd0, in_ready}, {63'd0, m_ready()});
            chk("imem_we",    {63'd0, imem_we},  {63'd0, m_pend});
            chk("imem_addr",  64'(imem_addr),
                64'((m_count < DEPTH) ? m_count : DEPTH - 1));
            chk("imem_wdata", 64'(imem_wdata), 64'(m_wdata));
            chk("count",      64'(count), 64'(m_count));
            chk("full",       {63'd0, full},  {63'd0, m_full});
            chk("error",      {63'd0, error}, {63'd0, m_err});
        end
    end

    // Strobe log for the directed literal checks.
    logic [ADDR_W-1:0] s_addr[$];
    logic [31:0]       s_data[$];
    always @(negedge clk) begin
        if (imem_we) begin
            s_addr.push_back(imem_addr);
            s_data.push_back(imem_wdata);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_in(input bit v, input logic [2:0] c, input logic [4:0] a, b, d, s,
                          input logic [5:0] f, input logic [15:0] im, input logic [25:0] t);
        in_valid = v; in_class = c; rs = a; rt = b; rd = d; shamt = s;
        funct = f; imm = im; target = t;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_clear();
        @(posedge clk); #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
    endtask

    // Present fields until accepted; returns #1 after the accepting edge.
    task automatic send(input logic [2:0] c, input logic [4:0] a, b, d, s,
                        input logic [5:0] f, input logic [15:0] im, input logic [25:0] t);
        bit ok = 0;
        @(posedge clk); #1;
        set_in(1'b1, c, a, b, d, s, f, im, t);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: in_ready never rose (got 0 expected 1)");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        // Model-pinning literals for the encoding function.
        chk("enc_r",    64'(enc(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0)), 64'h0022_1820);
        chk("enc_lw",   64'(enc(3'd1, 5'd29, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0004, 26'h0)), 64'h8FA8_0004);
        chk("enc_j",    64'(enc(3'd5, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0000010)), 64'h0800_0010);
        chk("enc_addi", 64'(enc(3'd4, 5'd0, 5'd1, 5'd0, 5'd0, 6'h0, 16'h0001, 26'h0)), 64'h2001_0001);

        @(posedge clk); #1 chk_en = 1;
        idle(2);
        reset = 1'b0;

        // R-type after reset: strobe one cycle after accept at address 0.
        send(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hBEEF, 26'h3FF_FFFF);
        @(negedge clk);
        chk("r_we",    {63'd0, imem_we}, 64'd1);
        chk("r_addr",  64'(imem_addr), 64'd0);
        chk("r_wdata", 64'(imem_wdata), 64'h0022_1820);
        @(posedge clk); #1;
        @(negedge clk);
        chk("r_count", 64'(count), 64'd1);

        // Back-to-back lw then j.
        do_clear();
        s_addr.delete(); s_data.delete();
        send(3'd1, 5'd29, 5'd8, 5'd7, 5'd3, 6'h3F, 16'h0004, 26'h155_5555);
        @(negedge clk);
        chk("lw_ready_write", {63'd0, in_ready}, 64'd0);
        send(3'd5, 5'd9, 5'd9, 5'd9, 5'd9, 6'h11, 16'h1234, 26'h0000010);
        @(negedge clk);
        chk("j_ready_write", {63'd0, in_ready}, 64'd0);
        idle(2);
        chk("b2b_nstrobes", 64'(s_addr.size()), 64'd2);
        if (s_addr.size() == 2) begin
            chk("b2b_addr0", 64'(s_addr[0]), 64'd0);
            chk("b2b_data0", 64'(s_data[0]), 64'h8FA8_0004);
            chk("b2b_addr1", 64'(s_addr[1]), 64'd1);
            chk("b2b_data1", 64'(s_data[1]), 64'h0800_0010);
        end

        // Fill the memory with valid held high.
        do_clear();
        s_addr.delete(); s_data.delete();
        @(posedge clk); #1;
        set_in(1'b1, 3'd4, 5'd0, 5'd1, 5'd0, 5'd0, 6'h0, 16'h0001, 26'h0);
        idle(20);
        in_valid = 1'b0;
        idle(1);
        chk("fill_nstrobes", 64'(s_addr.size()), 64'd4);
        for (int i = 0; i < s_addr.size() && i < 4; i++) begin
            chk("fill_addr", 64'(s_addr[i]), 64'(i));
            chk("fill_data", 64'(s_data[i]), 64'h2001_0001);
        end
        @(negedge clk);
        chk("fill_full",  {63'd0, full}, 64'd1);
        chk("fill_ready", {63'd0, in_ready}, 64'd0);
        chk("fill_addr_park", 64'(imem_addr), 64'd3);

        // Clear during the WRITE at address 2, then clear with valid.
        do_clear();
        send(3'd4, 5'd1, 5'd1, 5'd0, 5'd0, 6'h0, 16'h0011, 26'h0);
        send(3'd4, 5'd2, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0022, 26'h0);
        send(3'd4, 5'd3, 5'd3, 5'd0, 5'd0, 6'h0, 16'h0033, 26'h0);
        clear = 1'b1;
        @(negedge clk);
        chk("clrw_we",   {63'd0, imem_we}, 64'd1);
        chk("clrw_addr", 64'(imem_addr), 64'd2);
        @(posedge clk); #1 clear = 1'b0;
        @(negedge clk);
        chk("clrw_we_after", {63'd0, imem_we}, 64'd0);
        chk("clrw_count",    64'(count), 64'd0);
        chk("clrw_ptr",      64'(imem_addr), 64'd0);
        @(posedge clk); #1;
        clear = 1'b1;
        set_in(1'b1, 3'd0, 5'd4, 5'd5, 5'd6, 5'd7, 6'h2A, 16'h0, 26'h0);
        @(negedge clk);
        chk("clrv_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("clrv_no_we", {63'd0, imem_we}, 64'd0);

        // Illegal class 7.
        do_clear();
        s_addr.delete(); s_data.delete();
        send(3'd7, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FF_FFFF);
        idle(3);
        @(negedge clk);
        if (TRAP) begin
            chk("ill_nstrobes", 64'(s_addr.size()), 64'd0);
            chk("ill_error",    {63'd0, error}, 64'd1);
            chk("ill_count",    64'(count), 64'd0);
        end else begin
            chk("ill_nstrobes", 64'(s_addr.size()), 64'd1);
            if (s_data.size() > 0) chk("ill_wdata", 64'(s_data[0]), 64'h0);
            chk("ill_error",    {63'd0, error}, 64'd0);
            chk("ill_count",    64'(count), 64'd1);
        end

        // Randomized traffic with occasional clear and reset.
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            set_in(($urandom_range(0, 9) < 6), 3'($urandom_range(0, 7)),
                   5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                   6'($urandom), 16'($urandom), 26'($urandom));
            clear = ($urandom_range(0, 99) < 3);
            reset = ($urandom_range(0, 199) < 1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; clear = 1'b0; reset = 1'b0;
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
